// File: rtl/spi_pixel_master.sv
// SPI mode-0 transmitter feeding 16-bit pixel words to the matrix controller.
// Counts words per frame and pulses frame_done when a frame's last word completes.
module spi_pixel_master #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned WORD_WIDTH  = 16,
    parameter int unsigned FRAME_WORDS = 2048,
    parameter int unsigned GAP_CYCLES  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  frame_start,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    output logic                  busy,
    output logic [10:0]           word_count,
    output logic                  frame_done
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned GAP_W = 16;
    localparam int unsigned CNT_W = 11;
    localparam int unsigned BIT_W = $clog2(WORD_WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, GAP} state_t;

    state_t                state, state_nxt;
    logic [WORD_WIDTH-1:0] shift_reg, shift_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_nxt;
    logic [DIV_W-1:0]      div_cnt, div_nxt;
    logic [GAP_W-1:0]      gap_cnt, gap_nxt;
    logic                  start_pend, pend_nxt;
    logic                  ready_nxt, clk_nxt, mosi_nxt, busy_nxt, done_nxt;
    logic [CNT_W-1:0]      count_nxt;

    logic accept, div_last, gap_last, last_bit;

    assign accept   = in_valid && in_ready;
    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign gap_last = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign last_bit = (bit_cnt == '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = SHIFT_LO;
            SHIFT_LO: if (div_last) state_nxt = SHIFT_HI;
            SHIFT_HI: begin
                if (div_last) begin
                    if (!last_bit)            state_nxt = SHIFT_LO;
                    else if (GAP_CYCLES > 0)  state_nxt = GAP;
                    else                      state_nxt = IDLE;
                end
            end
            GAP:      if (gap_last) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        shift_nxt = shift_reg;
        bit_nxt   = bit_cnt;
        div_nxt   = div_cnt;
        gap_nxt   = gap_cnt;
        clk_nxt   = spi_clk;
        mosi_nxt  = spi_mosi;
        count_nxt = word_count;
        done_nxt  = 1'b0;
        pend_nxt  = start_pend | frame_start;
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                // A frame_start seen during the gap is honoured once idle
                if (frame_start || start_pend) begin
                    count_nxt = '0;
                    pend_nxt  = 1'b0;
                end
                if (accept) begin
                    shift_nxt = in_data;
                    mosi_nxt  = in_data[WORD_WIDTH-1];
                    bit_nxt   = BIT_W'(WORD_WIDTH - 1);
                    div_nxt   = '0;
                    clk_nxt   = 1'b0;
                end
            end
            SHIFT_LO: begin
                if (div_last) begin
                    div_nxt = '0;
                    clk_nxt = 1'b1;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    div_nxt = '0;
                    clk_nxt = 1'b0;
                    if (!last_bit) begin
                        shift_nxt = shift_reg << 1;
                        mosi_nxt  = shift_reg[WORD_WIDTH-2];
                        bit_nxt   = bit_cnt - BIT_W'(1);
                    end else begin
                        // Word complete: pending frame_start beats increment and wrap
                        gap_nxt = '0;
                        if (start_pend || frame_start) begin
                            count_nxt = '0;
                            pend_nxt  = 1'b0;
                        end else if (word_count == CNT_W'(FRAME_WORDS - 1)) begin
                            count_nxt = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            count_nxt = word_count + CNT_W'(1);
                        end
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            GAP: gap_nxt = gap_cnt + GAP_W'(1);
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            start_pend <= 1'b0;
            in_ready   <= 1'b0;
            spi_clk    <= 1'b0;
            spi_mosi   <= 1'b0;
            busy       <= 1'b0;
            word_count <= '0;
            frame_done <= 1'b0;
        end else begin
            shift_reg  <= shift_nxt;
            bit_cnt    <= bit_nxt;
            div_cnt    <= div_nxt;
            gap_cnt    <= gap_nxt;
            start_pend <= pend_nxt;
            in_ready   <= ready_nxt;
            spi_clk    <= clk_nxt;
            spi_mosi   <= mosi_nxt;
            busy       <= busy_nxt;
            word_count <= count_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule
